// File: rtl/m68k_bus_pkg.sv
// Shared types for the 68000-style bus initiator: FSM states, byte-enable codes, default timeout.
// Timeout abort is only compiled in with the BUS_TIMEOUT_EN macro; no latency or backpressure of its own.
package m68k_bus_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      STROBE,
      WAIT,
      DONE
   } state_t;

   localparam logic [1:0] BE_NONE  = 2'b00;
   localparam logic [1:0] BE_LOWER = 2'b01;
   localparam logic [1:0] BE_UPPER = 2'b10;
   localparam logic [1:0] BE_BOTH  = 2'b11;

   localparam int TIMEOUT_CYCLES_DEF = 15;
   localparam int WAIT_CNT_W         = 5;

   // An empty byte-enable mask would produce a cycle with no data strobe, so it means "both".
   function automatic logic [1:0] be_norm(input logic [1:0] be);
      return (be == BE_NONE) ? BE_BOTH : be;
   endfunction

endpackage

// File: rtl/m68k_strobe_gen.sv
// Combinational strobe decode: nAS/nUDS/nLDS and data output enable from state, RW and byte enables.
// Zero latency; no flow control, outputs follow the state register directly so reset releases them at once.
module m68k_strobe_gen
   import m68k_bus_pkg::*;
(
   input  state_t     state,
   input  logic       rw,
   input  logic [1:0] be,
   output logic       n_as,
   output logic       n_uds,
   output logic       n_lds,
   output logic       doe
);

   logic as_act;
   logic ds_act;

   always_comb begin
      as_act = (state == STROBE) || (state == WAIT);
      // Writes hold data strobes back one cycle so the data has settled before nUDS/nLDS fall.
      ds_act = (state == WAIT) || ((state == STROBE) && rw);
      n_as   = ~as_act;
      n_uds  = ~(ds_act && be[1]);
      n_lds  = ~(ds_act && be[0]);
      doe    = ~rw && ((state == ADDR) || (state == STROBE) || (state == WAIT));
   end

endmodule

// File: rtl/m68k_bus_initiator.sv
// 68000-style bus master: REQ/ACK port in, pin-level bus cycle out; optional timeout abort with BUS_TIMEOUT_EN.
// ACK 4 cycles after the request cycle plus one per nDTACK=1 sample; REQ is held until ACK/BERR, one request in flight.
module m68k_bus_initiator
   import m68k_bus_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
   parameter int ADDR_W         = 23
) (
   input  logic              CLK_68KCLK,
   input  logic              nRESET,
   input  logic              REQ,
   input  logic              REQ_WR,
   input  logic [ADDR_W-1:0] REQ_ADDR,
   input  logic [1:0]        REQ_BE,
   input  logic [15:0]       REQ_WDATA,
   output logic              ACK,
   output logic              BERR,
   output logic [15:0]       RDATA,
   output logic              BUSY,
   output logic [ADDR_W-1:0] M68K_ADDR,
   output logic [15:0]       M68K_DOUT,
   output logic              M68K_DOE,
   input  logic [15:0]       M68K_DIN,
   output logic              nAS,
   output logic              nUDS,
   output logic              nLDS,
   output logic              RW,
   input  logic              nDTACK
);

   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 31) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must lie within the 5-bit wait counter range 1..31");
   end

   state_t                  state_q, state_d;
   logic [ADDR_W-1:0]       addr_q, addr_d;
   logic                    wr_q, wr_d;
   logic [1:0]              be_q, be_d;
   logic [15:0]             wdata_q, wdata_d;
   logic [15:0]             rdata_q, rdata_d;
   logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;
   logic                    berr_q, berr_d;

`ifdef BUS_TIMEOUT_EN
   logic                    to_hit;
   assign to_hit = (int'(cnt_q) + 1) >= TIMEOUT_CYCLES;
`endif

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wr_d    = wr_q;
      be_d    = be_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      cnt_d   = cnt_q;
      berr_d  = berr_q;
      case (state_q)
         IDLE: begin
            cnt_d  = '0;
            berr_d = 1'b0;
            if (REQ) begin
               addr_d  = REQ_ADDR;
               wr_d    = REQ_WR;
               be_d    = be_norm(REQ_BE);
               wdata_d = REQ_WDATA;
               state_d = ADDR;
            end
         end
         ADDR:   state_d = STROBE;
         STROBE: state_d = WAIT;
         WAIT: begin
            if (!nDTACK) begin
               state_d = DONE;
               if (!wr_q) rdata_d = M68K_DIN;
            end else begin
               if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
`ifdef BUS_TIMEOUT_EN
               if (to_hit) begin
                  state_d = DONE;
                  berr_d  = 1'b1;
               end
`endif
            end
         end
         DONE: begin
            state_d = IDLE;
            berr_d  = 1'b0;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK_68KCLK or negedge nRESET) begin
      if (!nRESET) begin
         state_q <= IDLE;
         addr_q  <= '0;
         wr_q    <= 1'b0;
         be_q    <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         cnt_q   <= '0;
         berr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wr_q    <= wr_d;
         be_q    <= be_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         cnt_q   <= cnt_d;
         berr_q  <= berr_d;
      end
   end

   // RW is forced high in IDLE so a reset or a finished cycle leaves the bus in read direction.
   assign RW        = (state_q == IDLE) ? 1'b1 : ~wr_q;
   assign BUSY      = (state_q != IDLE);
   assign ACK       = (state_q == DONE) && !berr_q;
`ifdef BUS_TIMEOUT_EN
   assign BERR      = (state_q == DONE) && berr_q;
`else
   assign BERR      = 1'b0;
`endif
   assign RDATA     = rdata_q;
   assign M68K_ADDR = addr_q;
   assign M68K_DOUT = wdata_q;

   m68k_strobe_gen u_strobe (
      .state (state_q),
      .rw    (RW),
      .be    (be_q),
      .n_as  (nAS),
      .n_uds (nUDS),
      .n_lds (nLDS),
      .doe   (M68K_DOE)
   );

endmodule

// File: tb/tb_m68k_bus_initiator.sv
// Directed bench for m68k_bus_initiator: driver checks bus pins per cycle, a monitor pops expected ACK/BERR results.
// A responder process models nDTACK as tied low, stuck high, or asserted a fixed number of edges after nAS falls.
module tb_m68k_bus_initiator;

   localparam int AW = 23;
   localparam int TO = 15;

   logic          clk;
   logic          rst_n;
   logic          req;
   logic          req_wr;
   logic [AW-1:0] req_addr;
   logic [1:0]    req_be;
   logic [15:0]   req_wdata;
   logic          ack;
   logic          berr;
   logic [15:0]   rdata;
   logic          busy;
   logic [AW-1:0] bus_addr;
   logic [15:0]   bus_dout;
   logic          bus_doe;
   logic [15:0]   bus_din;
   logic          n_as;
   logic          n_uds;
   logic          n_lds;
   logic          rw;
   logic          n_dtack;

   m68k_bus_initiator #(.TIMEOUT_CYCLES(TO), .ADDR_W(AW)) dut (
      .CLK_68KCLK (clk),
      .nRESET     (rst_n),
      .REQ        (req),
      .REQ_WR     (req_wr),
      .REQ_ADDR   (req_addr),
      .REQ_BE     (req_be),
      .REQ_WDATA  (req_wdata),
      .ACK        (ack),
      .BERR       (berr),
      .RDATA      (rdata),
      .BUSY       (busy),
      .M68K_ADDR  (bus_addr),
      .M68K_DOUT  (bus_dout),
      .M68K_DOE   (bus_doe),
      .M68K_DIN   (bus_din),
      .nAS        (n_as),
      .nUDS       (n_uds),
      .nLDS       (n_lds),
      .RW         (rw),
      .nDTACK     (n_dtack)
   );

   typedef struct {
      logic        berr;
      logic [15:0] rdata;
      int          cyc;
   } exp_t;

   exp_t        exp_q[$];
   int          n_chk = 0;
   int          n_pass = 0;
   int          cyc = 0;
   int          dtack_lat = 0;   // 0: tied low, -1: never, N>=2: low from the N-th negedge with nAS low
   int          as_cnt = 0;
   int          hi_run = 0;
   int          lo_run = 0;
   int          last_hi = 0;
   int          last_lo = 0;
   logic [15:0] last_rd = 16'h0000;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endfunction

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc++;

   // nDTACK responder and nAS run-length tracker
   always @(negedge clk) begin
      if (!n_as) begin
         as_cnt++;
         lo_run++;
         if (hi_run > 0) last_hi = hi_run;
         hi_run = 0;
      end else begin
         as_cnt = 0;
         hi_run++;
         if (lo_run > 0) last_lo = lo_run;
         lo_run = 0;
      end
      if (dtack_lat == 0) n_dtack = 1'b0;
      else if (dtack_lat > 0 && as_cnt >= dtack_lat) n_dtack = 1'b0;
      else n_dtack = 1'b1;
   end

   // Scoreboard monitor: every ACK/BERR pulse consumes one expected completion
   always @(negedge clk) begin
      if (ack || berr) begin
         if (exp_q.size() == 0) begin
            chk("spurious_completion", {30'd0, ack, berr}, 32'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("ack", {31'd0, ack}, {31'd0, ~e.berr});
            chk("berr", {31'd0, berr}, {31'd0, e.berr});
            chk("completion_cycle", cyc, e.cyc);
            chk("rdata", {16'd0, rdata}, {16'd0, e.rdata});
         end
      end
   end

   // Issue one request at negedge+1 and check the pins on every cycle of the bus cycle.
   // lead = edges until acceptance: 1 from IDLE, 2 when called in DONE with REQ kept high.
   task automatic do_req(input logic wr, input logic [AW-1:0] addr, input logic [1:0] be,
                         input logic [15:0] wd, input logic [15:0] din, input int lat,
                         input logic exp_berr, input logic keep, input int lead);
      int         w;
      int         acc;
      logic [1:0] be_eff;
      exp_t       e;
      be_eff    = (be == 2'b00) ? 2'b11 : be;
      w         = exp_berr ? (TO - 1) : ((lat == 0) ? 0 : lat - 2);
      acc       = cyc + lead;
      req       = 1'b1;
      req_wr    = wr;
      req_addr  = addr;
      req_be    = be;
      req_wdata = wd;
      bus_din   = din;
      dtack_lat = lat;
      e.berr    = exp_berr;
      if (!exp_berr && !wr) last_rd = din;
      e.rdata   = last_rd;
      // Completion shows in the 4th cycle after the request cycle, i.e. 3 edges after acceptance, plus waits.
      e.cyc     = acc + 3 + w;
      exp_q.push_back(e);
      if (lead == 2) begin
         @(posedge clk);
         @(negedge clk); #1;
         chk("idle_gap_nas", {31'd0, n_as}, 32'd1);
         chk("idle_gap_rw", {31'd0, rw}, 32'd1);
         chk("idle_gap_busy", {31'd0, busy}, 32'd0);
      end
      @(posedge clk);
      for (int k = 0; k <= 3 + w; k++) begin
         logic str;
         logic wph;
         logic dne;
         @(negedge clk); #1;
         str = (k == 1);
         wph = (k >= 2) && (k <= 2 + w);
         dne = (k == 3 + w);
         chk("nAS", {31'd0, n_as}, {31'd0, ~(str | wph)});
         chk("nUDS", {31'd0, n_uds}, {31'd0, ~(be_eff[1] & (wph | (str & ~wr)))});
         chk("nLDS", {31'd0, n_lds}, {31'd0, ~(be_eff[0] & (wph | (str & ~wr)))});
         chk("doe", {31'd0, bus_doe}, {31'd0, wr & ~dne});
         chk("rw", {31'd0, rw}, {31'd0, ~wr});
         chk("busy", {31'd0, busy}, 32'd1);
         chk("bus_addr", {9'd0, bus_addr}, {9'd0, addr});
         if (wr) chk("bus_dout", {16'd0, bus_dout}, {16'd0, wd});
         if (k == 0) begin
            // Fields changed while busy must not reach the bus.
            req_addr  = ~addr;
            req_wdata = ~wd;
            req_be    = ~be;
            req_wr    = ~wr;
         end
         if (dne && !keep) req = 1'b0;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded its time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n     = 1'b0;
      req       = 1'b0;
      req_wr    = 1'b0;
      req_addr  = '0;
      req_be    = 2'b00;
      req_wdata = 16'h0000;
      bus_din   = 16'h0000;
      n_dtack   = 1'b1;
      #3;
      chk("rst_nas", {31'd0, n_as}, 32'd1);
      chk("rst_nuds", {31'd0, n_uds}, 32'd1);
      chk("rst_nlds", {31'd0, n_lds}, 32'd1);
      chk("rst_rw", {31'd0, rw}, 32'd1);
      chk("rst_doe", {31'd0, bus_doe}, 32'd0);
      chk("rst_ack_berr_busy", {29'd0, ack, berr, busy}, 32'd0);
      chk("rst_addr", {9'd0, bus_addr}, 32'd0);
      chk("rst_dout", {16'd0, bus_dout}, 32'd0);
      chk("rst_rdata", {16'd0, rdata}, 32'd0);
      repeat (3) @(negedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk); #1;

      // Zero-wait read, nDTACK tied low
      do_req(1'b0, 23'h000100, 2'b11, 16'h0000, 16'hA55A, 0, 1'b0, 1'b0, 1);
      @(negedge clk); #1;
      chk("read_nas_low_len", last_lo, 2);

      // Upper-byte write, two wait states
      do_req(1'b1, 23'h0ABCDE, 2'b10, 16'h1234, 16'hFFFF, 4, 1'b0, 1'b0, 1);
      @(negedge clk); #1;

      // BE=00 acts as both bytes, top address, one wait state
      do_req(1'b0, 23'h7FFFFF, 2'b00, 16'h0000, 16'h5AA5, 3, 1'b0, 1'b0, 1);
      @(negedge clk); #1;

      // Back-to-back reads with REQ held; DONE, IDLE and ADDR each keep nAS high
      do_req(1'b0, 23'h000200, 2'b11, 16'h0000, 16'h1111, 0, 1'b0, 1'b1, 1);
      do_req(1'b0, 23'h000202, 2'b01, 16'h0000, 16'h2222, 0, 1'b0, 1'b0, 2);
      chk("b2b_nas_high_gap", last_hi, 3);
      @(negedge clk); #1;

`ifdef BUS_TIMEOUT_EN
      // nDTACK stuck high: BERR after TO wait cycles, RDATA untouched
      do_req(1'b0, 23'h001000, 2'b11, 16'h0000, 16'hDEAD, -1, 1'b1, 1'b0, 1);
      @(negedge clk); #1;
      chk("berr_after_nas", {31'd0, n_as}, 32'd1);
`else
      // nDTACK high for 100 samples: WAIT holds, then completes
      do_req(1'b0, 23'h001000, 2'b11, 16'h0000, 16'hC3C3, 102, 1'b0, 1'b0, 1);
      @(negedge clk); #1;
`endif

      // Reset in the middle of a write's WAIT state
      req       = 1'b1;
      req_wr    = 1'b1;
      req_addr  = 23'h012345;
      req_be    = 2'b11;
      req_wdata = 16'hCAFE;
      dtack_lat = -1;
      repeat (4) @(posedge clk);
      @(negedge clk); #1;
      chk("pre_rst_busy", {31'd0, busy}, 32'd1);
      chk("pre_rst_nuds", {31'd0, n_uds}, 32'd0);
      rst_n = 1'b0;
      req   = 1'b0;
      #1;
      chk("midrst_strobes", {29'd0, n_as, n_uds, n_lds}, 32'd7);
      chk("midrst_doe", {31'd0, bus_doe}, 32'd0);
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      chk("midrst_ack_berr", {30'd0, ack, berr}, 32'd0);
      chk("midrst_rw", {31'd0, rw}, 32'd1);
      chk("midrst_addr", {9'd0, bus_addr}, 32'd0);
      chk("midrst_rdata", {16'd0, rdata}, 32'd0);
      last_rd = 16'h0000;
      @(negedge clk); #1 rst_n = 1'b1;
      @(negedge clk); #1;

      // First request after the abort completes normally
      do_req(1'b0, 23'h000040, 2'b11, 16'h0000, 16'hBEEF, 2, 1'b0, 1'b0, 1);
      repeat (3) @(negedge clk);
      #1;
      chk("queue_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
